codeur_iq: RTL and testbench



---
 rtl/codeur_iq_pkg.sv | 28 ++
 rtl/half_sine_lut.sv | 14 +
 rtl/codeur_iq.sv | 145 ++++++++++++++
 tb/tb_codeur_iq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/codeur_iq_pkg.sv
// Shared constants and types for the O-QPSK half-sine baseband modulator.
package codeur_iq_pkg;

  localparam int CHIP_CYCLES = 25;
  localparam int AMPLITUDE   = 7;
  localparam int LUT_DEPTH   = CHIP_CYCLES + 1;
  localparam int MAG_W       = $clog2(AMPLITUDE + 1);

  typedef logic signed [3:0] sample_t;
  typedef logic [4:0]        phase_t;
  typedef logic [MAG_W-1:0]  mag_t;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } parity_e;

  localparam phase_t K_LAST = phase_t'(CHIP_CYCLES - 1);
  localparam phase_t K_SPAN = phase_t'(CHIP_CYCLES);

  // round(7*sin(pi*n/50)), n = 0..25: a quarter sine spanning one chip period
  localparam mag_t HALF_SINE_LUT [LUT_DEPTH] = '{
    3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4,
    3'd4, 3'd4, 3'd5, 3'd5, 3'd5, 3'd6, 3'd6, 3'd6, 3'd6, 3'd7,
    3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7
  };

endpackage

// File: rtl/half_sine_lut.sv
// Combinational half-sine magnitude lookup, phase index -> 3-bit magnitude.
module half_sine_lut
  import codeur_iq_pkg::*;
(
  input  phase_t n,
  output mag_t   mag
);

  always_comb begin
    mag = '0;
    if (int'(n) < LUT_DEPTH) mag = HALF_SINE_LUT[n];
  end

endmodule

// File: rtl/codeur_iq.sv
// Offset-QPSK half-sine modulator: one chip per 25 clocks, signed 4-bit I/Q
// samples every clock, with differential sign update at chip boundaries.
module codeur_iq
  import codeur_iq_pkg::*;
(
  input  logic    clk,
  input  logic    resetn,
  input  logic    b_in,
  input  logic    en_2MHz,
  input  logic    mem_state,
  input  logic    dac_ready,
  output sample_t IBB,
  output sample_t QBB,
  output logic    ready
);

  function automatic sample_t apply_sign(input mag_t mag, input logic pos);
    sample_t m;
    m = sample_t'({1'b0, mag});
    return pos ? m : -m;
  endfunction

  phase_t  k_q, k_d;
  parity_e par_q, par_d;
  logic    first_q, first_d;
  logic    si_q, si_d;
  logic    sq_q, sq_d;
  logic    prev_q, prev_d;
  logic    en_prev_q;
  sample_t ibb_q, ibb_d;
  sample_t qbb_q, qbb_d;
  logic    ready_q, ready_d;

  logic    active;
  logic    en_edge;
  logic    k_wrap;
  logic    chip;
  logic    bound;
  phase_t  cos_n;
  mag_t    sin_mag;
  mag_t    cos_mag;

  assign active  = mem_state & dac_ready;
  assign en_edge = en_2MHz & ~en_prev_q;
  assign k_wrap  = (k_q == K_LAST);

  // Phase counter and chip boundary: signs, parity and previous chip
  always_comb begin
    k_d     = k_q;
    first_d = first_q;
    par_d   = par_q;
    si_d    = si_q;
    sq_d    = sq_q;
    prev_d  = prev_q;
    chip    = prev_q;
    bound   = 1'b0;
    if (!active) begin
      k_d     = '0;
      first_d = 1'b1;
      par_d   = PAR_EVEN;
      si_d    = 1'b1;
      sq_d    = 1'b1;
      prev_d  = 1'b0;
    end else begin
      chip  = en_edge ? b_in : prev_q;
      // Before the first real chip, a wrap carries no chip to reuse
      bound = en_edge | (k_wrap & ~first_q);
      k_d   = (en_edge | k_wrap) ? '0 : k_q + 5'd1;
      if (bound) begin
        prev_d = chip;
        if (first_q) begin
          first_d = 1'b0;
          par_d   = PAR_EVEN;
          si_d    = chip;
          sq_d    = 1'b1;
        end else if (par_q == PAR_EVEN) begin
          par_d = PAR_ODD;
          si_d  = ~(prev_q ^ chip ^ si_q);
        end else begin
          par_d = PAR_EVEN;
          sq_d  = ~(prev_q ^ chip ^ sq_q);
        end
      end
    end
  end

  assign cos_n = K_SPAN - k_d;

  half_sine_lut u_sin_lut (
    .n   (k_d),
    .mag (sin_mag)
  );

  half_sine_lut u_cos_lut (
    .n   (cos_n),
    .mag (cos_mag)
  );

  // Envelope selection by parity and sign application
  always_comb begin
    ibb_d   = '0;
    qbb_d   = '0;
    ready_d = active;
    if (active) begin
      if (par_d == PAR_ODD) begin
        ibb_d = apply_sign(sin_mag, si_d);
        qbb_d = apply_sign(cos_mag, sq_d);
      end else begin
        ibb_d = apply_sign(cos_mag, si_d);
        qbb_d = apply_sign(sin_mag, sq_d);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      k_q       <= '0;
      par_q     <= PAR_EVEN;
      first_q   <= 1'b1;
      si_q      <= 1'b1;
      sq_q      <= 1'b1;
      prev_q    <= 1'b0;
      en_prev_q <= 1'b0;
      ibb_q     <= '0;
      qbb_q     <= '0;
      ready_q   <= 1'b0;
    end else begin
      k_q       <= k_d;
      par_q     <= par_d;
      first_q   <= first_d;
      si_q      <= si_d;
      sq_q      <= sq_d;
      prev_q    <= prev_d;
      en_prev_q <= en_2MHz;
      ibb_q     <= ibb_d;
      qbb_q     <= qbb_d;
      ready_q   <= ready_d;
    end
  end

  assign IBB   = ibb_q;
  assign QBB   = qbb_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_codeur_iq.sv
// Scoreboard bench for codeur_iq: directed chip sequences with expected
// samples queued by the driver and compared by an independent monitor.
module tb_codeur_iq;

  logic clk = 1'b0;
  logic resetn;
  logic b_in;
  logic en_2MHz;
  logic mem_state;
  logic dac_ready;
  logic signed [3:0] IBB;
  logic signed [3:0] QBB;
  logic ready;

  codeur_iq dut (
    .clk       (clk),
    .resetn    (resetn),
    .b_in      (b_in),
    .en_2MHz   (en_2MHz),
    .mem_state (mem_state),
    .dac_ready (dac_ready),
    .IBB       (IBB),
    .QBB       (QBB),
    .ready     (ready)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic              ckiq;
    logic signed [3:0] i;
    logic signed [3:0] q;
    logic              rdy;
    string             nm;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  int lut [26] = '{0, 0, 1, 1, 2, 2, 3, 3, 3, 4, 4, 4, 5, 5, 5, 6, 6, 6, 6, 7,
                   7, 7, 7, 7, 7, 7};

  // Reference model state (1 = positive sign)
  logic m_first, m_odd, m_si, m_sq, m_prev;

  task automatic model_reset();
    m_first = 1'b1; m_odd = 1'b0; m_si = 1'b1; m_sq = 1'b1; m_prev = 1'b0;
  endtask

  task automatic model_boundary(input logic c);
    if (m_first) begin
      m_first = 1'b0; m_odd = 1'b0; m_si = c; m_sq = 1'b1;
    end else begin
      m_odd = !m_odd;
      if (m_odd) begin
        if (m_prev == c) m_si = !m_si;
      end else begin
        if (m_prev == c) m_sq = !m_sq;
      end
    end
    m_prev = c;
  endtask

  function automatic int msign(input int mag, input logic pos);
    return pos ? mag : -mag;
  endfunction

  task automatic step(input logic b, input logic en, input logic ms, input logic dr,
                      input logic rn, input logic ckiq, input int ei, input int eq,
                      input logic erdy, input string nm);
    exp_t e;
    @(negedge clk);
    b_in = b; en_2MHz = en; mem_state = ms; dac_ready = dr;
    if (!rn && resetn) begin
      resetn = 1'b0;
      #1;
      checks++;
      if (IBB !== 4'sd0 || QBB !== 4'sd0 || ready !== 1'b0) begin
        errors++;
        $display("FAIL async_zero: got I=%0d Q=%0d rdy=%b, want 0 0 0", IBB, QBB, ready);
      end
    end
    resetn = rn;
    e.ckiq = ckiq; e.i = 4'(ei); e.q = 4'(eq); e.rdy = erdy; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic send_chip(input logic b, input int ncyc, input logic use_edge,
                           input string nm);
    logic c;
    int   ei, eq;
    c = use_edge ? b : m_prev;
    model_boundary(c);
    for (int k = 0; k < ncyc; k++) begin
      if (m_odd) begin
        ei = msign(lut[k], m_si);      eq = msign(lut[25 - k], m_sq);
      end else begin
        ei = msign(lut[25 - k], m_si); eq = msign(lut[k], m_sq);
      end
      step(c, use_edge && (k < 13), 1'b1, 1'b1, 1'b1, 1'b1, ei, eq, 1'b1, nm);
    end
  endtask

  task automatic idle(input int n, input logic ms, input logic dr, input string nm);
    for (int j = 0; j < n; j++) step(1'b0, 1'b0, ms, dr, 1'b1, 1'b1, 0, 0, 1'b0, nm);
    model_reset();
  endtask

  // Monitor: one expected entry per clock, compared after the edge settles
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (ready !== e.rdy) begin
          errors++;
          $display("FAIL %s ready: got %b want %b", e.nm, ready, e.rdy);
        end
        if (e.ckiq) begin
          checks++;
          if (IBB !== e.i || QBB !== e.q) begin
            errors++;
            $display("FAIL %s iq: got I=%0d Q=%0d want I=%0d Q=%0d",
                     e.nm, IBB, QBB, e.i, e.q);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; b_in = 1'b0; en_2MHz = 1'b0; mem_state = 1'b1; dac_ready = 1'b1;
    model_reset();

    for (int j = 0; j < 5; j++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0, "reset");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1, "ready_rise");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1, "ready_hold");

    send_chip(1'b1, 25, 1'b1, "first_pos");
    send_chip(1'b0, 25, 1'b1, "odd_kept");
    send_chip(1'b1, 25, 1'b1, "even_q");
    send_chip(1'b1, 25, 1'b1, "odd_inv");
    send_chip(1'b0, 25, 1'b0, "wrap_reuse");
    send_chip(1'b1, 15, 1'b1, "early_cut");
    send_chip(1'b0, 25, 1'b1, "early_next");

    send_chip(1'b1, 9, 1'b1, "pre_drop");
    idle(43, 1'b1, 1'b0, "dac_drop");
    send_chip(1'b0, 25, 1'b1, "restart_neg");
    send_chip(1'b0, 25, 1'b1, "restart_2");

    idle(3, 1'b0, 1'b1, "mem_drop");
    send_chip(1'b1, 25, 1'b1, "mem_restart");

    send_chip(1'b1, 8, 1'b1, "pre_rst");
    for (int j = 0; j < 3; j++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0, "async_rst");
    model_reset();
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1, "post_rst");
    send_chip(1'b1, 25, 1'b1, "rst_restart");

    for (int n = 0; n < 60; n++) send_chip(1'($urandom_range(1, 0)), 25, 1'b1, "rand");

    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
